// File: rtl/tile_scheduler.sv
// Piano-tiles game engine: steps a song map into a falling-tile grid once per
// game frame and scores keypad presses against the bottom (hit) row.
module tile_scheduler #(
  parameter int FRAME_CYCLES = 25000000,
  parameter int ROWS         = 12,
  parameter int MAP_AW       = 6
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         keys,
  output logic [MAP_AW-1:0]   map_addr,
  input  logic [15:0]         map_data,
  output logic [16*ROWS-1:0]  grid,
  output logic [7:0]          game_frame,
  output logic                frame_tick,
  output logic [13:0]         score,
  output logic [7:0]          misses,
  output logic                busy,
  output logic                done
);

  localparam int            CW        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_CYCLES - 1);
  localparam logic [13:0]   SCORE_MAX = 14'd9990;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [16*ROWS-1:0] grid_q, grid_d;
  logic [7:0]         frame_q, frame_d;
  logic [13:0]        score_q, score_d;
  logic [7:0]         misses_q, misses_d;
  logic [MAP_AW-1:0]  addr_q, addr_d;
  logic               tick_q, tick_d;
  logic               hit_q, hit_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_end_q, pend_end_d;
  logic [3:0]         pend_note_q, pend_note_d;
  logic [3:0]         pend_len_q, pend_len_d;
  logic [7:0]         pend_start_q, pend_start_d;
  logic               act_valid_q, act_valid_d;
  logic [3:0]         act_note_q, act_note_d;
  logic [3:0]         act_remain_q, act_remain_d;

  logic [15:0]        bottom_row, top_row;
  logic [16*ROWS-1:0] shifted_grid;
  logic [CW-1:0]      cnt_next;
  logic               key_hit, tick, activate, song_over;
  logic [3:0]         note_eff, remain_eff;

  assign bottom_row   = grid_q[16*ROWS-1 -: 16];
  assign key_hit      = |(keys & bottom_row);
  assign tick         = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign cnt_next     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  // A newly activated note replaces whatever is playing (monophonic lane).
  assign activate     = pend_valid_q && (pend_start_q <= frame_q);
  assign note_eff     = activate ? pend_note_q : act_note_q;
  assign remain_eff   = activate ? pend_len_q : (act_valid_q ? act_remain_q : 4'd0);
  assign top_row      = (remain_eff != 4'd0) ? (16'd1 << note_eff) : 16'd0;
  assign shifted_grid = {grid_q[16*(ROWS-1)-1:0], top_row};
  assign song_over    = (frame_q == 8'd254) ||
                        (pend_end_q && (remain_eff <= 4'd1) && (shifted_grid == '0));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grid_d       = grid_q;
    frame_d      = frame_q;
    score_d      = score_q;
    misses_d     = misses_q;
    addr_d       = addr_q;
    tick_d       = 1'b0;
    hit_d        = hit_q;
    pend_valid_d = pend_valid_q;
    pend_end_d   = pend_end_q;
    pend_note_d  = pend_note_q;
    pend_len_d   = pend_len_q;
    pend_start_d = pend_start_q;
    act_valid_d  = act_valid_q;
    act_note_d   = act_note_q;
    act_remain_d = act_remain_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD_A;
          cnt_d        = '0;
          grid_d       = '0;
          frame_d      = '0;
          score_d      = '0;
          misses_d     = '0;
          addr_d       = '0;
          hit_d        = 1'b0;
          pend_valid_d = 1'b0;
          pend_end_d   = 1'b0;
          act_valid_d  = 1'b0;
          act_remain_d = '0;
        end
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
        cnt_d   = cnt_next;
      end
      S_LOAD_B: begin
        state_d      = S_RUN;
        cnt_d        = cnt_next;
        pend_note_d  = map_data[15:12];
        pend_len_d   = map_data[11:8];
        pend_start_d = map_data[7:0];
        pend_valid_d = (map_data[11:8] != 4'd0);
        pend_end_d   = (map_data[11:8] == 4'd0);
      end
      S_RUN: begin
        cnt_d = cnt_next;
        if (key_hit) hit_d = 1'b1;
        // Frame step: score the outgoing bottom row, then shift in the new top row.
        if (tick) begin
          tick_d = 1'b1;
          hit_d  = 1'b0;
          if (bottom_row != 16'd0) begin
            if (hit_q || key_hit)
              score_d = (score_q >= SCORE_MAX - 14'd10) ? SCORE_MAX : score_q + 14'd10;
            else if (misses_q != 8'hFF)
              misses_d = misses_q + 8'd1;
          end
          act_note_d   = note_eff;
          act_remain_d = (remain_eff != 4'd0) ? remain_eff - 4'd1 : 4'd0;
          act_valid_d  = (remain_eff > 4'd1);
          grid_d       = shifted_grid;
          frame_d      = frame_q + 8'd1;
          if (activate) begin
            pend_valid_d = 1'b0;
            addr_d       = addr_q + 1'b1;
            state_d      = S_LOAD_A;
          end
          if (song_over) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grid_q       <= '0;
      frame_q      <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      addr_q       <= '0;
      tick_q       <= 1'b0;
      hit_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_end_q   <= 1'b0;
      pend_note_q  <= '0;
      pend_len_q   <= '0;
      pend_start_q <= '0;
      act_valid_q  <= 1'b0;
      act_note_q   <= '0;
      act_remain_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grid_q       <= grid_d;
      frame_q      <= frame_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      addr_q       <= addr_d;
      tick_q       <= tick_d;
      hit_q        <= hit_d;
      pend_valid_q <= pend_valid_d;
      pend_end_q   <= pend_end_d;
      pend_note_q  <= pend_note_d;
      pend_len_q   <= pend_len_d;
      pend_start_q <= pend_start_d;
      act_valid_q  <= act_valid_d;
      act_note_q   <= act_note_d;
      act_remain_q <= act_remain_d;
    end
  end

  assign map_addr   = addr_q;
  assign grid       = grid_q;
  assign game_frame = frame_q;
  assign frame_tick = tick_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign busy       = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: directed song table, hand-written
// corner sequences, and random songs checked against a frame-level model.
module tb_tile_scheduler;

  localparam int FC   = 8;
  localparam int ROWS = 12;
  localparam int AW   = 6;

  logic                CLOCK_50 = 1'b0;
  logic                rst_n    = 1'b0;
  logic                start    = 1'b0;
  logic [15:0]         keys     = 16'h0;
  logic [AW-1:0]       map_addr;
  logic [15:0]         map_data;
  logic [16*ROWS-1:0]  grid;
  logic [7:0]          game_frame;
  logic                frame_tick;
  logic [13:0]         score;
  logic [7:0]          misses;
  logic                busy;
  logic                done;

  logic [15:0] rom [0:63];
  int checks = 0;
  int fails  = 0;

  typedef struct {
    string            name;
    logic [3:0][15:0] words;
    logic [15:0]      keyVal;
    int               expScore;
    int               expMisses;
    int               expFrame;
  } vec_t;
  vec_t vecs [7];

  int          songN;
  int          songNote  [32];
  int          songLen   [32];
  int          songStart [32];
  logic [15:0] expTop    [256];
  logic [15:0] keysFrame [257];
  int          expDoneF, expScore, expMisses;

  tile_scheduler #(.FRAME_CYCLES(FC), .ROWS(ROWS), .MAP_AW(AW)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .start     (start),
    .keys      (keys),
    .map_addr  (map_addr),
    .map_data  (map_data),
    .grid      (grid),
    .game_frame(game_frame),
    .frame_tick(frame_tick),
    .score     (score),
    .misses    (misses),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous song ROM: data follows the address one cycle later.
  always @(posedge CLOCK_50) map_data <= rom[map_addr];

  function automatic logic [15:0] mk(input int note, input int len, input int st);
    return {4'(note), 4'(len), 8'(st)};
  endfunction

  function automatic vec_t mkVec(input string nm, input logic [3:0][15:0] w, input logic [15:0] k,
                                 input int s, input int m, input int f);
    vec_t v;
    v.name = nm; v.words = w; v.keyVal = k;
    v.expScore = s; v.expMisses = m; v.expFrame = f;
    return v;
  endfunction

  function automatic logic [16*ROWS-1:0] expGrid(input int f);
    logic [16*ROWS-1:0] g = '0;
    for (int r = 0; r < ROWS; r++)
      if (f - r >= 0) g[16*r +: 16] = expTop[f-r];
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    start = 1'b0;
    keys  = 16'h0;
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0;
  endtask

  task automatic applyStimulus();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic waitTick(output bit ok);
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!frame_tick && n < 2*FC + 4);
    ok = frame_tick;
    if (!ok) checkOutput("frame_tick timeout", frame_tick, 1);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput("done reached", done, 1);
  endtask

  task automatic runVector(input vec_t v);
    resetDut();
    clearRom();
    for (int i = 0; i < 4; i++) rom[i] = v.words[i];
    keys = v.keyVal;
    applyStimulus();
    waitDone(300*FC);
    checkOutput({v.name, " score"}, score, v.expScore);
    checkOutput({v.name, " misses"}, misses, v.expMisses);
    checkOutput({v.name, " frame"}, game_frame, v.expFrame);
    checkOutput({v.name, " busy"}, busy, 0);
  endtask

  // Frame-level reference: notes are taken in song order at most one per frame,
  // each lighting its lane on the top row for len frames unless a later note cuts it.
  task automatic computeModel();
    int idx = 0;
    int cur = 0;
    int rem = 0;
    bit endPend, zero;
    expDoneF = 254;
    for (int f = 0; f < 256; f++) expTop[f] = 16'h0;
    for (int f = 0; f < 255; f++) begin
      endPend = (idx == songN);
      if (idx < songN && songStart[idx] <= f) begin
        cur = songNote[idx];
        rem = songLen[idx];
        idx++;
      end
      expTop[f] = (rem > 0) ? 16'(1 << cur) : 16'h0;
      if (rem > 0) rem--;
      zero = 1'b1;
      for (int r = 0; r < ROWS; r++)
        if (f - r >= 0 && expTop[f-r] != 16'h0) zero = 1'b0;
      if (f == 254 || (endPend && rem == 0 && zero)) begin
        expDoneF = f;
        break;
      end
    end
  endtask

  task automatic computeScore();
    logic [15:0] b;
    expScore  = 0;
    expMisses = 0;
    for (int f = 0; f <= expDoneF; f++) begin
      b = (f >= ROWS) ? expTop[f-ROWS] : 16'h0;
      if (b != 16'h0) begin
        if ((keysFrame[f] & b) != 16'h0) expScore = (expScore + 10 > 9990) ? 9990 : expScore + 10;
        else if (expMisses < 255) expMisses++;
      end
    end
  endtask

  task automatic genSong();
    int st = 0;
    songN = $urandom_range(0, 20);
    for (int i = 0; i < songN; i++) begin
      st += $urandom_range(0, 12);
      songNote[i]  = $urandom_range(0, 15);
      songLen[i]   = $urandom_range(1, 15);
      songStart[i] = st;
    end
  endtask

  task automatic genKeys();
    logic [15:0] b;
    int r;
    for (int f = 0; f < 257; f++) begin
      b = (f >= ROWS && f < 256 + ROWS) ? expTop[(f-ROWS) % 256] : 16'h0;
      r = $urandom_range(0, 3);
      if (r < 2 && b != 16'h0) keysFrame[f] = b;
      else if (r == 2)         keysFrame[f] = 16'h0;
      else                     keysFrame[f] = 16'(1 << $urandom_range(0, 15));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int lastFrame;
    logic [3:0][15:0] single, seq4;
    single = {16'h0, 16'h0, 16'h0, mk(0, 2, 0)};
    seq4   = {mk(3, 4, 12), mk(2, 4, 8), mk(1, 4, 4), mk(0, 4, 0)};
    vecs[0] = mkVec("single hit",  single, 16'h0001, 20, 0, 14);
    vecs[1] = mkVec("single miss", single, 16'h0002, 0, 2, 14);
    vecs[2] = mkVec("empty song",  {16'h0, 16'h0, 16'h0, 16'h0}, 16'h0001, 0, 0, 1);
    vecs[3] = mkVec("seq no keys", seq4, 16'h0000, 0, 16, 28);
    vecs[4] = mkVec("seq lane2",   seq4, 16'h0004, 40, 12, 28);
    vecs[5] = mkVec("truncation",  {16'h0, 16'h0, mk(7, 2, 3), mk(5, 8, 0)}, 16'h0080, 20, 3, 17);
    vecs[6] = mkVec("delayed len1", {16'h0, 16'h0, 16'h0, mk(3, 1, 2)}, 16'h0008, 10, 0, 15);

    clearRom();
    resetDut();
    checkOutput("reset grid", grid, 0);
    checkOutput("reset state", {score, misses, game_frame, map_addr, frame_tick, busy, done}, 0);

    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    $display("[TB] single-note tick timing");
    resetDut();
    clearRom();
    rom[0] = mk(0, 2, 0);
    applyStimulus();
    checkOutput("busy after start", busy, 1);
    repeat (7) @(negedge CLOCK_50);
    checkOutput("no tick before cycle 8", frame_tick, 0);
    @(negedge CLOCK_50);
    checkOutput("tick at cycle 8", frame_tick, 1);
    checkOutput("tick1 grid", grid, 192'h0001);
    checkOutput("tick1 frame", game_frame, 1);
    @(negedge CLOCK_50);
    checkOutput("tick is one cycle", frame_tick, 0);
    waitTick(ok);
    checkOutput("tick2 grid", grid, 192'h0001_0001);
    waitTick(ok);
    checkOutput("tick3 grid", grid, 192'h0001_0001_0000);

    $display("[TB] sequential notes and map_addr stepping");
    resetDut();
    clearRom();
    for (int i = 0; i < 4; i++) rom[i] = seq4[i];
    applyStimulus();
    checkOutput("seq addr start", map_addr, 0);
    for (int k = 1; k <= 16; k++) begin
      waitTick(ok);
      checkOutput("seq row0", grid[15:0], 16'(1 << ((k-1)/4)));
      checkOutput("seq map_addr", map_addr, ((k-1)/4) + 1);
    end

    $display("[TB] start during RUN is ignored");
    resetDut();
    clearRom();
    rom[0] = mk(0, 2, 0);
    keys = 16'h0001;
    applyStimulus();
    repeat (3) waitTick(ok);
    applyStimulus();
    checkOutput("run start frame", game_frame, 3);
    checkOutput("run start addr", map_addr, 1);
    waitDone(300*FC);
    checkOutput("run start score", score, 20);
    checkOutput("run start end frame", game_frame, 14);

    $display("[TB] start in DONE restarts the song");
    applyStimulus();
    checkOutput("restart score", score, 0);
    checkOutput("restart grid", grid, 0);
    checkOutput("restart frame/addr", {game_frame, map_addr}, 0);
    checkOutput("restart busy/done", {busy, done}, 2'b10);
    waitDone(300*FC);
    checkOutput("restart final score", score, 20);

    $display("[TB] asynchronous reset mid-song");
    applyStimulus();
    repeat (13) waitTick(ok);
    checkOutput("pre-reset score", score, 10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset grid", grid, 0);
    checkOutput("async reset outputs", {score, misses, game_frame, map_addr, frame_tick, busy, done}, 0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;

    $display("[TB] game_frame cap at 255");
    resetDut();
    clearRom();
    for (int i = 0; i < 18; i++) rom[i] = mk(i % 16, 15, 15*i);
    applyStimulus();
    waitDone(260*FC);
    checkOutput("cap frame", game_frame, 255);
    checkOutput("cap misses", misses, 243);

    $display("[TB] random songs against reference model");
    for (int s = 0; s < 8; s++) begin
      genSong();
      computeModel();
      genKeys();
      computeScore();
      resetDut();
      clearRom();
      for (int i = 0; i < songN; i++) rom[i] = mk(songNote[i], songLen[i], songStart[i]);
      keys = keysFrame[0];
      applyStimulus();
      lastFrame = -1;
      for (int f = 0; f <= expDoneF; f++) begin
        waitTick(ok);
        if (!ok) break;
        checkOutput("rnd frame", game_frame, f + 1);
        checkOutput("rnd grid", grid, expGrid(f));
        checkOutput("rnd done", done, (f == expDoneF));
        keys = keysFrame[f+1];
        lastFrame = f;
      end
      if (lastFrame == expDoneF) begin
        checkOutput("rnd score", score, expScore);
        checkOutput("rnd misses", misses, expMisses);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
